// File: rtl/bs_pkg.sv
// Shared types and helpers for the Battleship player core.
package bs_pkg;

  // Widest board the helpers accept; narrower vectors are zero-extended.
  localparam int unsigned MAX_W = 32;
  localparam int unsigned PC_W  = 6;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_READY  = 3'd1,
    ST_ATTACK = 3'd2,
    ST_DEFEND = 3'd3,
    ST_WIN    = 3'd4,
    ST_LOSE   = 3'd5
  } bs_state_t;

  // Number of set bits in a board vector.
  function automatic logic [PC_W-1:0] popcount(input logic [MAX_W-1:0] v);
    logic [PC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(MAX_W); i++) begin
      cnt = cnt + PC_W'(v[i]);
    end
    return cnt;
  endfunction

  // True when exactly one bit is set.
  function automatic logic is_onehot(input logic [MAX_W-1:0] v);
    return (v != '0) && ((v & (v - MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/bs_attack_checker.sv
// Combinational accept/reject of a proposed attack vector.
// With BS_ATTACK_CHECK_EN defined an attack must be one-hot and not a repeat;
// otherwise any non-zero vector is accepted.
module bs_attack_checker
  import bs_pkg::*;
#(
  parameter int unsigned BOARD_W = 10
) (
  input  logic [BOARD_W-1:0] cell_sw,
  input  logic [BOARD_W-1:0] history,
  output logic               accept_c
);

`ifdef BS_ATTACK_CHECK_EN
  // Single target cell that has not been fired at before.
  assign accept_c = is_onehot(MAX_W'(cell_sw)) && ((cell_sw & history) == '0);
`else
  // Any non-empty target is allowed; history is not kept in this build.
  logic unused_history;
  assign unused_history = ^history;
  assign accept_c       = |cell_sw;
`endif

endmodule

// File: rtl/bs_player_core.sv
// One player's Battleship board: load, attack, defend, win/lose sequencing.
// Optional feature macro: BS_ATTACK_CHECK_EN (one-hot, no-repeat attack check).
module bs_player_core
  import bs_pkg::*;
#(
  parameter int unsigned BOARD_W  = 10,
  parameter int unsigned SHIP_MAX = 4,
  parameter int unsigned FIRST    = 1,
  parameter int unsigned CNT_W    = $clog2(BOARD_W + 1)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [BOARD_W-1:0] cell_sw,
  input  logic               load_btn,
  input  logic               fire_btn,
  input  logic [BOARD_W-1:0] opp_attack,
  input  logic               opp_valid,
  input  logic               opp_ready,
  input  logic               opp_alive,
  output logic [BOARD_W-1:0] attack_out,
  output logic               attack_valid,
  output logic               ready,
  output logic [BOARD_W-1:0] ships,
  output logic               alive,
  output logic [CNT_W-1:0]   hits_taken,
  output logic               err,
  output logic [2:0]         state
);

  localparam int unsigned SUM_W = PC_W + 1;

  bs_state_t          st;
  logic               load_prev;
  logic               fire_prev;
  logic               load_rise;
  logic               fire_rise;
  logic [BOARD_W-1:0] history;
  logic               accept_c;
  logic               attack_take;
  logic [PC_W-1:0]    ship_cnt;
  logic               ship_ok;
  logic [BOARD_W-1:0] ships_nxt;
  logic [PC_W-1:0]    hit_cnt;
  logic [SUM_W-1:0]   hit_sum;
  logic [CNT_W-1:0]   hits_sat;

  // Button edge detection; prev flops reset high so a held button never fires.
  assign load_rise = load_btn & ~load_prev;
  assign fire_rise = fire_btn & ~fire_prev;

  // Placement must occupy between one and SHIP_MAX cells.
  assign ship_cnt = popcount(MAX_W'(cell_sw));
  assign ship_ok  = (ship_cnt != '0) && (ship_cnt <= PC_W'(SHIP_MAX));

  // Incoming hit bookkeeping with saturation at the board size.
  assign ships_nxt = ships & ~opp_attack;
  assign hit_cnt   = popcount(MAX_W'(ships & opp_attack));
  assign hit_sum   = SUM_W'(hits_taken) + SUM_W'(hit_cnt);
  assign hits_sat  = (hit_sum > SUM_W'(BOARD_W)) ? CNT_W'(BOARD_W) : CNT_W'(hit_sum);

  // An attack is committed only in ATTACK while the opponent is still alive.
  assign attack_take = (st == ST_ATTACK) && opp_alive && fire_rise && accept_c;

  bs_attack_checker #(
    .BOARD_W (BOARD_W)
  ) u_checker (
    .cell_sw  (cell_sw),
    .history  (history),
    .accept_c (accept_c)
  );

`ifdef BS_ATTACK_CHECK_EN
  // Shot history: every accepted target is remembered until clr.
  always_ff @(posedge clk) begin
    if (clr) begin
      history <= '0;
    end else if (attack_take) begin
      history <= history | cell_sw;
    end
  end
`else
  assign history = '0;
`endif

  // Turn sequencer with its registered outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      st           <= ST_LOAD;
      load_prev    <= 1'b1;
      fire_prev    <= 1'b1;
      ships        <= '0;
      attack_out   <= '0;
      attack_valid <= 1'b0;
      hits_taken   <= '0;
      err          <= 1'b0;
    end else begin
      load_prev    <= load_btn;
      fire_prev    <= fire_btn;
      attack_valid <= 1'b0;
      case (st)
        ST_LOAD: begin
          if (load_rise) begin
            if (ship_ok) begin
              ships <= cell_sw;
              st    <= ST_READY;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_READY: begin
          if (opp_ready) begin
            st <= (FIRST != 0) ? ST_ATTACK : ST_DEFEND;
          end
        end
        ST_ATTACK: begin
          if (!opp_alive) begin
            st <= ST_WIN;
          end else if (fire_rise) begin
            if (accept_c) begin
              attack_out   <= cell_sw;
              attack_valid <= 1'b1;
              err          <= 1'b0;
              st           <= ST_DEFEND;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_DEFEND: begin
          if (!opp_alive) begin
            st <= ST_WIN;
          end else if (opp_valid) begin
            ships      <= ships_nxt;
            hits_taken <= hits_sat;
            st         <= (ships_nxt == '0) ? ST_LOSE : ST_ATTACK;
          end
        end
        ST_WIN, ST_LOSE: begin
          st <= st;
        end
        default: begin
          st <= ST_LOAD;
        end
      endcase
    end
  end

  // Status decoded straight from the state and ship flops.
  assign ready = (st != ST_LOAD);
  assign alive = (ships != '0) || (st == ST_LOAD);
  assign state = st;

endmodule
